adc_scan_averager: RTL

Parametrised ADC scan sequencer and averager that sits between application logic and the modular ADC control core's command/response streams. It walks a contiguous range of channels, issues 2^AVG_LOG2 conversions per channel with one command outstanding at a time, and accumulates and averages the responses. It emits one averaged result per channel on a ready/valid stream, in single-scan or continuous mode.

---
 rtl/adc_scan_averager.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/adc_scan_averager.sv
// ADC scan sequencer: walks CH_BASE..CH_BASE+NUM_CH-1, averages 2^AVG_LOG2
// conversions per channel with one command outstanding, streams one result per channel.
module adc_scan_averager #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CH_BASE  = 1,
    parameter int unsigned CH_W     = 5,
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              start,
    input  logic              continuous,
    output logic              command_valid,
    output logic [CH_W-1:0]   command_channel,
    output logic              command_startofpacket,
    output logic              command_endofpacket,
    input  logic              command_ready,
    input  logic              response_valid,
    input  logic [CH_W-1:0]   response_channel,
    input  logic [DATA_W-1:0] response_data,
    output logic              result_valid,
    output logic [CH_W-1:0]   result_channel,
    output logic [DATA_W-1:0] result_data,
    input  logic              result_ready,
    output logic              busy,
    output logic              scan_done,
    output logic              err_mismatch
);

    localparam int unsigned IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W   = AVG_LOG2 + 1;
    localparam int unsigned ACC_W   = DATA_W + AVG_LOG2;
    localparam int unsigned SAMPLES = 1 << AVG_LOG2;

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WAIT, ST_OUT} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;

    logic              cmd_valid_q, cmd_valid_d;
    logic [CH_W-1:0]   cmd_ch_q, cmd_ch_d;
    logic              cmd_sop_q, cmd_sop_d;
    logic              cmd_eop_q, cmd_eop_d;
    logic              res_valid_q, res_valid_d;
    logic [CH_W-1:0]   res_ch_q, res_ch_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [CH_W-1:0]   cur_ch;
    logic              cmd_hs, res_hs, resp_hit, resp_miss, last_idx, last_cnt;

    always_comb begin
        cur_ch    = CH_W'(CH_BASE) + CH_W'(idx_q);
        cmd_hs    = cmd_valid_q & command_ready;
        res_hs    = res_valid_q & result_ready;
        resp_hit  = (state_q == ST_WAIT) && response_valid && (response_channel == cur_ch);
        resp_miss = (state_q == ST_WAIT) && response_valid && (response_channel != cur_ch);
        last_idx  = (idx_q == IDX_W'(NUM_CH - 1));
        last_cnt  = (cnt_q == CNT_W'(SAMPLES - 1));
    end

    // State register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus scan index, sample count and accumulator
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (cmd_hs) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (resp_hit) begin
                    acc_d   = acc_q + ACC_W'(response_data);
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = last_cnt ? ST_OUT : ST_CMD;
                end else if (resp_miss) begin
                    state_d = ST_CMD;
                end
            end
            ST_OUT: begin
                if (res_hs) begin
                    acc_d = '0;
                    cnt_d = '0;
                    if (!last_idx) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_CMD;
                    end else begin
                        idx_d   = '0;
                        state_d = continuous ? ST_CMD : ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state
    always_comb begin
        cmd_valid_d = (state_d == ST_CMD);
        cmd_ch_d    = cmd_valid_d ? CH_W'(CH_BASE) + CH_W'(idx_d) : '0;
        cmd_sop_d   = cmd_valid_d && (idx_d == '0) && (cnt_d == '0);
        cmd_eop_d   = cmd_valid_d && (idx_d == IDX_W'(NUM_CH - 1))
                      && (cnt_d == CNT_W'(SAMPLES - 1));
        res_valid_d = (state_d == ST_OUT);
        res_ch_d    = res_ch_q;
        res_data_d  = res_data_q;
        if ((state_q == ST_WAIT) && (state_d == ST_OUT)) begin
            res_ch_d   = cur_ch;
            res_data_d = DATA_W'(acc_d >> AVG_LOG2);
        end
        busy_d = (state_d != ST_IDLE);
        done_d = res_hs && last_idx;
        err_d  = err_q | resp_miss;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            idx_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_ch_q    <= '0;
            cmd_sop_q   <= 1'b0;
            cmd_eop_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_ch_q    <= cmd_ch_d;
            cmd_sop_q   <= cmd_sop_d;
            cmd_eop_q   <= cmd_eop_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign command_valid         = cmd_valid_q;
    assign command_channel       = cmd_ch_q;
    assign command_startofpacket = cmd_sop_q;
    assign command_endofpacket   = cmd_eop_q;
    assign result_valid          = res_valid_q;
    assign result_channel        = res_ch_q;
    assign result_data           = res_data_q;
    assign busy                  = busy_q;
    assign scan_done             = done_q;
    assign err_mismatch          = err_q;

endmodule
